// File: rtl/matmult_seq_ctrl.sv
// Address/accumulator sequencer for the matmult datapath: C = A x B, N x N, N <= DIM_MAX.
// Build option MATMULT_CTRL_TRANSPOSE_B_EN: B stored transposed, b_addr = j*N + k.
//
// state  | meaning
// IDLE   | waiting for start; dim validated on acceptance
// RUN    | one operand read per cycle, k = 0..N-1
// DRAIN  | last product of the element enters the MAC
// WRITE  | accumulator written to C at i*N + j
// FIN    | one-cycle done pulse
module matmult_seq_ctrl #(
    parameter int DIM_MAX = 8,
    parameter int ADDR_W  = 6
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [3:0]        dim,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              c_we
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [3:0] DIM_MAX_C = 4'(DIM_MAX);

    logic [2:0]        state_q, state_d;
    logic [3:0]        n_q, n_d;
    logic [3:0]        i_q, i_d;
    logic [3:0]        j_q, j_d;
    logic [3:0]        k_q, k_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic              err_q, err_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_clr_q, mac_clr_d;

    logic [ADDR_W-1:0] n_w;
    logic              k_last, j_last, i_last, dim_bad;

    assign n_w     = ADDR_W'(n_q);
    assign k_last  = (k_q == n_q - 4'd1);
    assign j_last  = (j_q == n_q - 4'd1);
    assign i_last  = (i_q == n_q - 4'd1);
    assign dim_bad = (dim == 4'd0) || (dim > DIM_MAX_C);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        row_base_d = row_base_q;
        b_base_d   = b_base_q;
        err_d      = err_q;
        // MAC strobes trail the read strobe by the RAM latency; abort kills the in-flight one
        mac_en_d   = (state_q == S_RUN) && !abort;
        mac_clr_d  = (state_q == S_RUN) && (k_q == 4'd0) && !abort;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    n_d        = dim;
                    i_d        = 4'd0;
                    j_d        = 4'd0;
                    k_d        = 4'd0;
                    row_base_d = '0;
                    b_base_d   = '0;
                    err_d      = dim_bad;
                    state_d    = dim_bad ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (k_last) begin
                    k_d     = 4'd0;
                    state_d = S_DRAIN;
`ifndef MATMULT_CTRL_TRANSPOSE_B_EN
                    b_base_d = '0;
`endif
                end else begin
                    k_d = k_q + 4'd1;
`ifndef MATMULT_CTRL_TRANSPOSE_B_EN
                    b_base_d = b_base_q + n_w;
`endif
                end
            end
            S_DRAIN: begin
                state_d = abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (j_last) begin
                    j_d        = 4'd0;
                    i_d        = i_q + 4'd1;
                    row_base_d = row_base_q + n_w;
`ifdef MATMULT_CTRL_TRANSPOSE_B_EN
                    b_base_d = '0;
`endif
                    state_d    = i_last ? S_FIN : S_RUN;
                end else begin
                    j_d = j_q + 4'd1;
`ifdef MATMULT_CTRL_TRANSPOSE_B_EN
                    b_base_d = b_base_q + n_w;
`endif
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            n_q        <= 4'd0;
            i_q        <= 4'd0;
            j_q        <= 4'd0;
            k_q        <= 4'd0;
            row_base_q <= '0;
            b_base_q   <= '0;
            err_q      <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            row_base_q <= row_base_d;
            b_base_q   <= b_base_d;
            err_q      <= err_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done    = (state_q == S_FIN);
    assign err     = err_q;
    assign rd_en   = (state_q == S_RUN);
    assign c_we    = (state_q == S_WRITE);
    assign mac_en  = mac_en_q;
    assign mac_clr = mac_clr_q;

    assign a_addr = rd_en ? (row_base_q + ADDR_W'(k_q)) : '0;
`ifdef MATMULT_CTRL_TRANSPOSE_B_EN
    assign b_addr = rd_en ? (b_base_q + ADDR_W'(k_q)) : '0;
`else
    assign b_addr = rd_en ? (b_base_q + ADDR_W'(j_q)) : '0;
`endif
    assign c_addr = c_we ? (row_base_q + ADDR_W'(j_q)) : '0;

endmodule

// File: tb/tb_matmult_seq_ctrl.sv
// Self-checking bench for matmult_seq_ctrl with a behavioural RAM/MAC datapath around it.
// Honours MATMULT_CTRL_TRANSPOSE_B_EN for the B storage layout and expected b_addr.
module tb_matmult_seq_ctrl;

    localparam int DIM_MAX = 8;
    localparam int ADDR_W  = 6;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        dim = 4'd0;
    logic              abort = 1'b0;
    logic              busy, done, err, rd_en, mac_en, mac_clr, c_we;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem_a [64];
    logic [15:0] mem_b [64];
    logic [15:0] a_rd = 16'd0;
    logic [15:0] b_rd = 16'd0;
    logic [31:0] acc = 32'd0;

    typedef struct {int a; int b;} rd_t;
    typedef struct {int addr; int val;} wr_t;
    rd_t rd_q[$];
    wr_t wr_q[$];

    matmult_seq_ctrl #(.DIM_MAX(DIM_MAX), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .dim(dim), .abort(abort),
        .busy(busy), .done(done), .err(err), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en), .mac_clr(mac_clr),
        .c_addr(c_addr), .c_we(c_we)
    );

    always #5 ACLK = ~ACLK;

    // Operand RAMs (1-cycle read latency) and MAC driven by the DUT strobes
    always @(posedge ACLK) begin
        if (rd_en) begin
            a_rd <= mem_a[a_addr];
            b_rd <= mem_b[b_addr];
        end
        if (mac_en)
            acc <= mac_clr ? 32'(a_rd) * 32'(b_rd) : acc + 32'(a_rd) * 32'(b_rd);
    end

    task automatic test_reset();
        logic [24:0] outs;
        ARESETN = 1'b0; start = 1'b1; dim = 4'd3; abort = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        outs = {busy, done, err, rd_en, mac_en, mac_clr, c_we, a_addr, b_addr, c_addr};
        checks++;
        if (outs !== 25'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=0", outs);
        end
        start = 1'b0; ARESETN = 1'b1;
        @(negedge ACLK); start = 1'b1; dim = 4'd3;
        repeat (6) begin
            @(posedge ACLK); #1 start = 1'b0;
        end
        @(negedge ACLK);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_prerun_busy got=%b exp=1", busy);
        end
        ARESETN = 1'b0; start = 1'b1; abort = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        outs = {busy, done, err, rd_en, mac_en, mac_clr, c_we, a_addr, b_addr, c_addr};
        checks++;
        if (outs !== 25'd0) begin
            failures++;
            $display("FAIL reset_midrun got=%h exp=0", outs);
        end
        ARESETN = 1'b1; start = 1'b0; abort = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({busy, done, rd_en} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=000", {busy, done, rd_en});
        end
    endtask

    // mode 0: A=1..N*N, B=5..; mode 1: random bytes; mode 2: all ones
    task automatic test_matmult(input int n, input int mode, input string name);
        int t, clr_cnt, sum;
        int av[8][8];
        int bv[8][8];
        rd_t r;
        wr_t w;
        logic exp_busy, exp_done;
        t = n * n * (n + 2);
        clr_cnt = 0;
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                av[i][j] = (mode == 0) ? i * n + j + 1 : (mode == 1) ? int'($urandom_range(0, 255)) : 1;
                bv[i][j] = (mode == 0) ? i * n + j + 5 : (mode == 1) ? int'($urandom_range(0, 255)) : 1;
            end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                mem_a[i * n + j] = 16'(av[i][j]);
`ifdef MATMULT_CTRL_TRANSPOSE_B_EN
                mem_b[j * n + i] = 16'(bv[i][j]);
`else
                mem_b[i * n + j] = 16'(bv[i][j]);
`endif
            end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                sum = 0;
                for (int k = 0; k < n; k++) begin
                    sum += av[i][k] * bv[k][j];
                    r.a = i * n + k;
`ifdef MATMULT_CTRL_TRANSPOSE_B_EN
                    r.b = j * n + k;
`else
                    r.b = k * n + j;
`endif
                    rd_q.push_back(r);
                end
                w.addr = i * n + j;
                w.val  = sum;
                wr_q.push_back(w);
            end

        @(negedge ACLK); start = 1'b1; dim = 4'(n);
        for (int cyc = 1; cyc <= t + 2; cyc++) begin
            @(posedge ACLK); #1 start = 1'b0;
            @(negedge ACLK);
            exp_busy = (cyc <= t);
            exp_done = (cyc == t + 1);
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, done, exp_done);
            end
            if (cyc == 1) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL %s err_clear got=%b exp=0", name, err);
                end
            end
            if (rd_en === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_read cyc=%0d got=rd_en exp=idle", name, cyc);
                end else begin
                    r = rd_q.pop_front();
                    if (a_addr !== ADDR_W'(r.a) || b_addr !== ADDR_W'(r.b)) begin
                        failures++;
                        $display("FAIL %s rd_addr cyc=%0d got=a%0d/b%0d exp=a%0d/b%0d",
                                 name, cyc, a_addr, b_addr, r.a, r.b);
                    end
                end
            end
            if (mac_en === 1'b1 && mac_clr === 1'b1) clr_cnt++;
            if (c_we === 1'b1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_write cyc=%0d got=c_we exp=idle", name, cyc);
                end else begin
                    w = wr_q.pop_front();
                    if (c_addr !== ADDR_W'(w.addr) || acc !== 32'(w.val)) begin
                        failures++;
                        $display("FAIL %s c_write cyc=%0d got=addr%0d/val%0d exp=addr%0d/val%0d",
                                 name, cyc, c_addr, acc, w.addr, w.val);
                    end
                end
                checks++;
                if (mac_en !== 1'b0) begin
                    failures++;
                    $display("FAIL %s we_mac_overlap cyc=%0d got=%b exp=0", name, cyc, mac_en);
                end
            end
        end
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending got=rd%0d/wr%0d exp=0/0", name, rd_q.size(), wr_q.size());
        end
        checks++;
        if (clr_cnt != n * n) begin
            failures++;
            $display("FAIL %s mac_clr_count got=%0d exp=%0d", name, clr_cnt, n * n);
        end
    endtask

    task automatic test_invalid();
        logic [3:0] bad_dims [2];
        bad_dims[0] = 4'd0;
        bad_dims[1] = 4'd9;
        for (int b = 0; b < 2; b++) begin
            @(negedge ACLK); start = 1'b1; dim = bad_dims[b];
            for (int cyc = 1; cyc <= 3; cyc++) begin
                @(posedge ACLK); #1 start = 1'b0;
                @(negedge ACLK);
                checks++;
                if (done !== (cyc == 1)) begin
                    failures++;
                    $display("FAIL invalid_done dim=%0d cyc=%0d got=%b exp=%b", bad_dims[b], cyc, done, cyc == 1);
                end
                checks++;
                if ({err, busy, rd_en, c_we, mac_en} !== 5'b10000) begin
                    failures++;
                    $display("FAIL invalid_flags dim=%0d cyc=%0d got=%b exp=10000",
                             bad_dims[b], cyc, {err, busy, rd_en, c_we, mac_en});
                end
            end
        end
    endtask

    task automatic test_abort();
        int wcnt;
        wcnt = 0;
        @(negedge ACLK); start = 1'b1; dim = 4'd4;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge ACLK); #1
            start = (cyc == 5);
            dim   = (cyc == 5) ? 4'd2 : 4'd4;
            abort = (cyc == 20);
            @(negedge ACLK);
            if (c_we === 1'b1) wcnt++;
            checks++;
            if (cyc <= 20) begin
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_busy_run cyc=%0d got=%b exp=1", cyc, busy);
                end
            end else if ({busy, rd_en, mac_en, c_we, done} !== 5'b00000) begin
                failures++;
                $display("FAIL abort_quiet cyc=%0d got=%b exp=00000", cyc, {busy, rd_en, mac_en, c_we, done});
            end
        end
        checks++;
        if (wcnt != 3 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_writes got=%0d/err%b exp=3/err0", wcnt, err);
        end
        @(negedge ACLK); start = 1'b1; abort = 1'b1; dim = 4'd2;
        @(posedge ACLK); #1 start = 1'b0; abort = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge ACLK);
            checks++;
            if ({busy, rd_en, done} !== 3'b000) begin
                failures++;
                $display("FAIL abort_start_idle cyc=%0d got=%b exp=000", cyc, {busy, rd_en, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge ACLK); start = 1'b1; dim = 4'd2;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(posedge ACLK); #1 start = (cyc == 17);
            @(negedge ACLK);
            if (cyc == 17) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_done got=%b exp=1", done);
                end
            end
            if (cyc >= 18) begin
                checks++;
                if ({busy, rd_en} !== 2'b00) begin
                    failures++;
                    $display("FAIL b2b_fin_start cyc=%0d got=%b exp=00", cyc, {busy, rd_en});
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_matmult(2, 0, "n2_example");
        test_matmult(3, 1, "n3_trace");
        test_matmult(8, 2, "n8_ones");
        test_invalid();
        test_matmult(2, 1, "n2_after_err");
        test_abort();
        test_matmult(2, 0, "n2_after_abort");
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
